// File: rtl/ej5_sweep_ctrl.sv
// ej5_sweep_ctrl: exhaustive-sweep sequencer for the ej5 three-input block.
// It steps {A,B,C} through all 2^K vectors and holds each one for
// SETTLE_CYCLES cycles so the combinational outputs can settle. It then
// compares every original function against its simplified twin, counts the
// failing vectors and captures the first failure.
//
// Start/done handshake: start is a level. It is sampled only while the
// controller is idle (IDLE or DONE). A high sample launches a sweep and
// clears the previous results on that same edge. busy stays high for the
// whole sweep. done stays high, with pass/err_count/first_err_* stable,
// until reset or the next accepted start.
`timescale 1ns/1ps

module ej5_sweep_ctrl #(
  parameter int K             = 3,
  parameter int NOUT          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [K-1:0]    abc,
  input  logic [NOUT-1:0] func_a,
  input  logic [NOUT-1:0] func_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [K:0]      err_count,
  output logic [K-1:0]    first_err_vec,
  output logic [NOUT-1:0] first_err_mask,
  output logic [1:0]      dbg_state
);

  // The settle counter only ever holds values 0..SETTLE_CYCLES-1.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD   = CW'(SETTLE_CYCLES - 1);
  localparam logic [K-1:0]  LAST_VEC = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [K-1:0]    r_abc;
  logic [K:0]      r_err_count;
  logic [K-1:0]    r_first_vec;
  logic [NOUT-1:0] r_first_mask;
  logic            r_pass;

  logic            w_start_sweep;
  logic [NOUT-1:0] w_mism;
  logic            w_hit;
  logic [K:0]      w_err_next;

  // Mismatch is only meaningful in COMPARE, once abc has settled.
  assign w_mism     = func_a ^ func_b;
  assign w_hit      = (r_state == COMPARE) && (w_mism != '0);
  assign w_err_next = r_err_count + {{K{1'b0}}, w_hit};

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a start accepted from IDLE or DONE launches a sweep.
  always_comb begin
    w_next        = r_state;
    w_start_sweep = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next        = SETTLE;
          w_start_sweep = 1'b1;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) w_next = COMPARE;
      end
      COMPARE: begin
        if (r_abc == LAST_VEC) w_next = DONE;
        else                   w_next = SETTLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: vector stepping, settle timing, error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_abc        <= '0;
      r_cnt        <= '0;
      r_err_count  <= '0;
      r_first_vec  <= '0;
      r_first_mask <= '0;
      r_pass       <= 1'b0;
    end else if (w_start_sweep) begin
      r_abc        <= '0;
      r_cnt        <= RELOAD;
      r_err_count  <= '0;
      r_first_vec  <= '0;
      r_first_mask <= '0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        COMPARE: begin
          if (w_hit) begin
            r_err_count <= w_err_next;
            if (r_err_count == '0) begin
              r_first_vec  <= r_abc;
              r_first_mask <= w_mism;
            end
          end
          // Terminal check comes before any increment, so abc never wraps.
          if (r_abc == LAST_VEC) begin
            r_pass <= (w_err_next == '0);
          end else begin
            r_abc <= r_abc + 1'b1;
            r_cnt <= RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign abc            = r_abc;
  assign busy           = (r_state == SETTLE) || (r_state == COMPARE);
  assign done           = (r_state == DONE);
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_err_vec  = r_first_vec;
  assign first_err_mask = r_first_mask;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_ej5_sweep_ctrl.sv
// tb_ej5_sweep_ctrl: directed bench for ej5_sweep_ctrl. There are two
// instances: one with the default settle time and one with SETTLE_CYCLES=3.
// A behavioural ej5 stand-in feeds func_a. func_b is func_a with
// mode-selected bit flips.
`timescale 1ns/1ps

module tb_ej5_sweep_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       start0, start1;
  logic [2:0] abc0, abc1;
  logic [3:0] fa0, fb0, fa1, fb1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic [2:0] vec0, vec1;
  logic [3:0] mask0, mask1;
  logic [1:0] st0, st1;
  int         mode0, mode1;

  ej5_sweep_ctrl #(.K(3), .NOUT(4), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abc(abc0),
    .func_a(fa0), .func_b(fb0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_vec(vec0), .first_err_mask(mask0),
    .dbg_state(st0)
  );

  ej5_sweep_ctrl #(.K(3), .NOUT(4), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abc(abc1),
    .func_a(fa1), .func_b(fb1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_vec(vec1), .first_err_mask(mask1),
    .dbg_state(st1)
  );

  // ---------------- ej5 stand-in ----------------
  function automatic logic [3:0] fa_model(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return {a & b, b | c, a ^ c, ~a & b};
  endfunction

  // mode 0: equal; 1: bit2 flipped at abc==5; 2: all inverted; 3: bit0 flipped at abc==1
  function automatic logic [3:0] fb_model(input int mode, input logic [2:0] v,
                                          input logic [3:0] fa);
    logic [3:0] r;
    case (mode)
      1:       r = (v == 3'd5) ? (fa ^ 4'b0100) : fa;
      2:       r = ~fa;
      3:       r = (v == 3'd1) ? (fa ^ 4'b0001) : fa;
      default: r = fa;
    endcase
    return r;
  endfunction

  always_comb begin
    fa0 = fa_model(abc0);
    fb0 = fb_model(mode0, abc0, fa0);
    fa1 = fa_model(abc1);
    fb1 = fb_model(mode1, abc1, fa1);
  end

  // ---------------- scoreboard ----------------
  // packed expectation: [19:12] latency, [11] pass, [10:7] err, [6:4] vec, [3:0] mask
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  int checks   = 0;
  int failures = 0;
  int t0_0 = 0, t0_1 = 0;

  function automatic logic [19:0] exp_pack(input int lat, input logic p,
      input logic [3:0] e, input logic [2:0] v, input logic [3:0] m);
    return {8'(lat), p, e, v, m};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: compare the full result whenever done rises.
  logic done0_q = 1'b0, done1_q = 1'b0;
  always @(negedge clk) begin
    logic [19:0] e;
    if (done0 && !done0_q) begin
      if (exp_q0.size() == 0) begin
        check("sb0_unexpected_done", 1, 0);
      end else begin
        e = exp_q0.pop_front();
        check("sb0_latency",   cyc - t0_0,     int'(e[19:12]));
        check("sb0_pass",      int'(pass0),    int'(e[11]));
        check("sb0_err_count", int'(err0),     int'(e[10:7]));
        check("sb0_first_vec", int'(vec0),     int'(e[6:4]));
        check("sb0_first_mask",int'(mask0),    int'(e[3:0]));
      end
    end
    done0_q = done0;
  end

  always @(negedge clk) begin
    logic [19:0] e;
    if (done1 && !done1_q) begin
      if (exp_q1.size() == 0) begin
        check("sb1_unexpected_done", 1, 0);
      end else begin
        e = exp_q1.pop_front();
        check("sb1_latency",   cyc - t0_1,     int'(e[19:12]));
        check("sb1_pass",      int'(pass1),    int'(e[11]));
        check("sb1_err_count", int'(err1),     int'(e[10:7]));
        check("sb1_first_vec", int'(vec1),     int'(e[6:4]));
        check("sb1_first_mask",int'(mask1),    int'(e[3:0]));
      end
    end
    done1_q = done1;
  end

  // ---------------- driver tasks ----------------
  // Returns at the negedge after the edge that sampled start (E0).
  task automatic start_sweep0();
    @(negedge clk);
    start0 = 1'b1;
    t0_0   = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic start_sweep1();
    @(negedge clk);
    start1 = 1'b1;
    t0_1   = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_done0(input int limit);
    int n = 0;
    while (!done0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done0) check("wait_done0_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done1(input int limit);
    int n = 0;
    while (!done1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done1) check("wait_done1_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_abc0(input logic [2:0] v, input int limit);
    int n = 0;
    while (abc0 != v && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (abc0 != v) check("wait_abc0_timeout", int'(abc0), int'(v));
  endtask

  task automatic check_idle0(input string tag);
    check({tag, "_abc"},   int'(abc0),  0);
    check({tag, "_busy"},  int'(busy0), 0);
    check({tag, "_done"},  int'(done0), 0);
    check({tag, "_pass"},  int'(pass0), 0);
    check({tag, "_err"},   int'(err0),  0);
    check({tag, "_vec"},   int'(vec0),  0);
    check({tag, "_mask"},  int'(mask0), 0);
    check({tag, "_state"}, int'(st0),   0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode0  = 0;
    mode1  = 3;
    repeat (3) @(negedge clk);
    check_idle0("reset");
    check("reset_busy1", int'(busy1), 0);
    check("reset_done1", int'(done1), 0);
    reset = 1'b0;
    @(negedge clk);

    // T1: clean sweep; abc held two cycles per vector
    exp_q0.push_back(exp_pack(16, 1'b1, 4'd0, 3'd0, 4'b0000));
    start_sweep0();
    for (int n = 0; n < 16; n++) begin
      check($sformatf("t1_abc_e%0d", n), int'(abc0), n / 2);
      if (n == 15) begin
        check("t1_busy_last", int'(busy0), 1);
        check("t1_done_early", int'(done0), 0);
      end
      @(negedge clk);
    end
    wait_done0(40);

    // T2: single injected mismatch at abc==5, bit 2
    mode0 = 1;
    exp_q0.push_back(exp_pack(16, 1'b0, 4'd1, 3'd5, 4'b0100));
    start_sweep0();
    wait_done0(40);

    // T3: every vector fails
    mode0 = 2;
    exp_q0.push_back(exp_pack(16, 1'b0, 4'd8, 3'd0, 4'b1111));
    start_sweep0();
    wait_done0(40);

    // T4: start pulsed mid-sweep is ignored
    mode0 = 0;
    exp_q0.push_back(exp_pack(16, 1'b1, 4'd0, 3'd0, 4'b0000));
    start_sweep0();
    wait_abc0(3'd3, 40);
    check("t4_busy_at_pulse", int'(busy0), 1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(40);

    // T5: reset mid-sweep returns everything to idle on the next edge
    start_sweep0();
    wait_abc0(3'd3, 40);
    reset = 1'b1;
    @(negedge clk);
    check_idle0("t5_midreset");
    reset = 1'b0;
    @(negedge clk);

    // T6: failing sweep, then restart from DONE clears the results
    mode0 = 2;
    exp_q0.push_back(exp_pack(16, 1'b0, 4'd8, 3'd0, 4'b1111));
    start_sweep0();
    wait_done0(40);
    mode0 = 0;
    exp_q0.push_back(exp_pack(16, 1'b1, 4'd0, 3'd0, 4'b0000));
    start_sweep0();
    check("t6_err_cleared",  int'(err0),  0);
    check("t6_vec_cleared",  int'(vec0),  0);
    check("t6_mask_cleared", int'(mask0), 0);
    check("t6_done_fell",    int'(done0), 0);
    check("t6_pass_low",     int'(pass0), 0);
    check("t6_busy",         int'(busy0), 1);
    wait_done0(40);

    // T7: SETTLE_CYCLES=3 instance, mismatch at abc==1
    exp_q1.push_back(exp_pack(32, 1'b0, 4'd1, 3'd1, 4'b0001));
    start_sweep1();
    for (int n = 0; n < 32; n++) begin
      check($sformatf("t7_abc_e%0d", n), int'(abc1), n / 4);
      @(negedge clk);
    end
    wait_done1(40);

    // ---------------- report ----------------
    if (exp_q0.size() != 0) check("sb0_leftover", exp_q0.size(), 0);
    if (exp_q1.size() != 0) check("sb1_leftover", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ej5_sweep_ctrl.md
Name: ej5_sweep_ctrl

Overview:
Sequencer for the ej5 three-input combinational block. It drives A,B,C through every input combination, lets the outputs settle, and compares each original function (f,g,h,l) against its simplified counterpart (fb,gb,hb,lb). It counts mismatches and records the first failing vector. It sits between a start/status interface, such as board switches/LEDs or a top-level bench, and the ej5 instance.

Parameters:
K, 3, number of ej5 inputs; sweep covers 0..2^K-1
NOUT, 4, number of function pairs compared
SETTLE_CYCLES, 1, cycles each vector is held before compare; legal range >=1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin sweep; sampled only in IDLE or DONE
abc  out  K  vector driven to ej5 as {A,B,C}, MSB = A
func_a  in  NOUT  {f,g,h,l} from ej5
func_b  in  NOUT  {fb,gb,hb,lb} from ej5
busy  out  1  high in SETTLE and COMPARE
done  out  1  high in DONE
pass  out  1  high in DONE when err_count==0
err_count  out  K+1  number of vectors with at least one mismatching pair
first_err_vec  out  K  abc value of the first mismatching vector
first_err_mask  out  NOUT  func_a^func_b captured at the first mismatch

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous, active-high, and all registers sample on the rising clk edge.
  - Reset, including mid-sweep, forces IDLE on the next edge. abc, busy, done, pass, err_count, first_err_vec and first_err_mask all return to 0.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE:
  - Outputs are held at 0.
  - start=1 at an edge moves to SETTLE. On that same edge: abc=0, settle counter=SETTLE_CYCLES-1, and err_count, first_err_vec and first_err_mask are cleared.
- SETTLE:
  - abc is stable and the counter decrements each cycle.
  - When the counter is 0, go to COMPARE.
  - Each vector is therefore held SETTLE_CYCLES cycles in SETTLE plus 1 cycle in COMPARE.
- COMPARE:
  - mism = func_a ^ func_b is evaluated combinationally against the current abc.
  - If mism != 0: err_count increments.
  - If mism != 0 and err_count was 0 before this increment: first_err_vec=abc and first_err_mask=mism.
  - If abc == 2^K-1: go to DONE; abc holds its final value.
  - Otherwise: abc=abc+1, counter reloaded, go to SETTLE.
  - No wrap-around occurs.
- DONE:
  - done=1, and pass=(err_count==0) as a registered value.
  - Results hold until reset or a new start.
  - start=1 at an edge in DONE behaves exactly like start in IDLE: results are cleared, abc=0, and the state goes to SETTLE.
- start handling:
  - start is ignored while busy.
  - start is level-sensitive: if it is held high continuously, a new sweep begins on the first edge in DONE.
- Latency:
  - Let E0 be the edge that samples start.
  - done rises after edge E0 + 2^K*(SETTLE_CYCLES+1).
  - Defaults: 16 edges.
- Width rules:
  - err_count has K+1 bits. Its maximum is 2^K, so no saturation is needed.
  - abc increments modulo-free; the terminal check precedes any increment.
- Simultaneous events: reset has priority over start and over all state transitions.

Test Plan:
- Defaults, func_b tied to func_a -> abc steps 0..7, each held 2 cycles; done=1 exactly 16 edges after start; pass=1; err_count=0; first_err_vec=0; first_err_mask=0.
- func_b = func_a except bit 2 inverted only when abc==5 -> err_count=1, first_err_vec=5, first_err_mask=4'b0100, pass=0.
- func_b = ~func_a always -> err_count=8, first_err_vec=0, first_err_mask=4'b1111, pass=0.
- start pulsed while abc==3 and busy -> ignored, sweep completes normally at 16 edges. Then assert reset while abc==3 in a second sweep -> next edge: IDLE, all outputs 0, busy=0.
- After a failing sweep sits in DONE, pulse start with func_b=func_a -> err_count and first_err_* clear on the start edge, done falls, and the new sweep ends with pass=1.
- SETTLE_CYCLES=3 with an injected mismatch at abc==1 -> each vector held 4 cycles, done at 32 edges, err_count=1, first_err_vec=1.
